// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the two-requester multiplier arbiter:
// FSM state encodings and requester identifiers.
package mult_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

endpackage

// File: rtl/mult_arb_pick.sv
// Combinational winner select for the multiplier arbiter.
// Build option ARB_ROUND_ROBIN_EN: defined -> round-robin on conflict
// (rr_ptr=1 means requester 1 is preferred); undefined -> fixed priority,
// requester 0 always wins and rr_ptr is ignored.
module mult_arb_pick
    import mult_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic gnt_id,
    output logic any_req
);

    assign any_req = req0 | req1;

`ifdef ARB_ROUND_ROBIN_EN
    // On a conflict the pointer decides; a lone request always wins
    always_comb begin
        gnt_id = REQ_ID0;
        if (req0 && req1) begin
            gnt_id = rr_ptr ? REQ_ID1 : REQ_ID0;
        end else if (req1) begin
            gnt_id = REQ_ID1;
        end
    end
`else
    logic unused_rr_ptr;
    assign unused_rr_ptr = rr_ptr;

    // Requester 0 wins whenever it is asking
    always_comb begin
        gnt_id = REQ_ID0;
        if (!req0 && req1) begin
            gnt_id = REQ_ID1;
        end
    end
`endif

endmodule

// File: rtl/mult_arbiter.sv
// Shares one shift-add multiplier between two requesters. Arbitrates,
// latches the winner's operands, pulses mul_start, waits for mul_done or a
// watchdog timeout, then returns the product with a one-cycle ack.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (see mult_arb_pick).
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 2*WIDTH+4
) (
    input  logic                 clk,
    input  logic                 resetCU,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 ack0,
    output logic                 ack1,
    output logic                 err,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 mul_start,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [2*WIDTH-1:0]   mul_product
);

    localparam int CW = $clog2(TIMEOUT+1);

    state_t               state_reg, state_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic                 gnt_reg, gnt_next;
    logic                 rr_reg, rr_next;
    logic [WIDTH-1:0]     a_reg, a_next, b_reg, b_next;
    logic [2*WIDTH-1:0]   prod_reg, prod_next;
    logic                 err_reg, err_next;
    logic                 start_reg, start_next;
    logic                 busy_reg, busy_next;
    logic [1:0]           ack_reg, ack_next;
    logic                 pick_id, any_req;

    mult_arb_pick u_pick (
        .req0    (req0),
        .req1    (req1),
        .rr_ptr  (rr_reg),
        .gnt_id  (pick_id),
        .any_req (any_req)
    );

    // State register
    always_ff @(posedge clk) begin
        if (resetCU) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt_next   = gnt_reg;
        rr_next    = rr_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        prod_next  = prod_reg;
        err_next   = err_reg;
        start_next = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_GRANT;
                    gnt_next   = pick_id;
                    a_next     = (pick_id == REQ_ID1) ? a1 : a0;
                    b_next     = (pick_id == REQ_ID1) ? b1 : b0;
                    start_next = 1'b1;
                end
            end
            ST_GRANT: begin
                state_next = ST_BUSY;
                cnt_next   = '0;
            end
            ST_BUSY: begin
                cnt_next = cnt_reg + 1'b1;
                // done takes precedence over an expiring watchdog
                if (mul_done) begin
                    state_next = ST_RESP;
                    prod_next  = mul_product;
                    err_next   = 1'b0;
                end else if (cnt_reg == CW'(TIMEOUT-1)) begin
                    state_next = ST_RESP;
                    prod_next  = '0;
                    err_next   = 1'b1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
                rr_next    = ~gnt_reg;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // The ack pulse is launched as RESP exits, so busy stays up through it
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign ack_next[gi] = (state_reg == ST_RESP) && (gnt_reg == 1'(gi));
    end

    assign busy_next = (state_next != ST_IDLE) || (state_reg == ST_RESP);

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (resetCU) begin
            cnt_reg   <= '0;
            gnt_reg   <= REQ_ID0;
            rr_reg    <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            prod_reg  <= '0;
            err_reg   <= 1'b0;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            ack_reg   <= '0;
        end else begin
            cnt_reg   <= cnt_next;
            gnt_reg   <= gnt_next;
            rr_reg    <= rr_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            prod_reg  <= prod_next;
            err_reg   <= err_next;
            start_reg <= start_next;
            busy_reg  <= busy_next;
            ack_reg   <= ack_next;
        end
    end

    assign ack0      = ack_reg[0];
    assign ack1      = ack_reg[1];
    assign err       = err_reg;
    assign product   = prod_reg;
    assign busy      = busy_reg;
    assign mul_start = start_reg;
    assign mul_a     = a_reg;
    assign mul_b     = b_reg;

endmodule
